// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        FILL  = 2'd2,
        FLUSH = 2'd3
    } dcacheState_t;

    localparam logic [1:0] DWM_WORD = 2'b00;
    localparam logic [1:0] DWM_BYTE = 2'b01;
    localparam logic [1:0] DWM_HALF = 2'b10;

    // Byte-offset bits covering one line; index bits covering all sets.
    function automatic int unsigned offsetWidth(input int unsigned lineWords);
        return $clog2(lineWords) + 2;
    endfunction

    function automatic int unsigned indexWidth(input int unsigned sets);
        return $clog2(sets);
    endfunction

    localparam int unsigned DEF_LINE_WORDS = 8;
    localparam int unsigned DEF_SETS       = 64;
    localparam int unsigned DEF_OFFSET_W   = offsetWidth(DEF_LINE_WORDS);
    localparam int unsigned DEF_INDEX_W    = indexWidth(DEF_SETS);

endpackage

// File: rtl/dcache_store_merge.sv
// Big-endian byte/half/word merge of store data into an existing cache word.
module dcache_store_merge
    import dcache_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [31:0] storeData,
    input  logic [1:0]  mode,
    input  logic [1:0]  byteSel,
    output logic [31:0] mergedWord
);

    always_comb begin
        mergedWord = storeData;
        case (mode)
            DWM_BYTE: begin
                mergedWord = oldWord;
                case (byteSel)
                    2'd0:    mergedWord[31:24] = storeData[7:0];
                    2'd1:    mergedWord[23:16] = storeData[7:0];
                    2'd2:    mergedWord[15:8]  = storeData[7:0];
                    default: mergedWord[7:0]   = storeData[7:0];
                endcase
            end
            DWM_HALF: begin
                mergedWord = oldWord;
                if (byteSel[1]) mergedWord[15:0]  = storeData[15:0];
                else            mergedWord[31:16] = storeData[15:0];
            end
            default: mergedWord = storeData;
        endcase
    end

endmodule

// File: rtl/dcache_wb.sv
// Write-back direct-mapped data cache with acknowledged block transfers.
// Optional whole-cache flush on SYS when DCACHE_FLUSH_EN is defined.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned SETS       = DEF_SETS,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    SYS,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [1:0]              DataWriteMode,
    input  logic [ADDR_W-1:0]       data_address_2DM,
    input  logic [31:0]             data_write_2DM,
    output logic [31:0]             data_read_fDC,
    output logic                    DMISS,
    output logic                    dBlkRead,
    output logic                    dBlkWrite,
    output logic [ADDR_W-1:0]       blk_addr,
    output logic [32*LINE_WORDS-1:0] block_write_2DM,
    input  logic [32*LINE_WORDS-1:0] block_read_fDM,
    input  logic                    blk_ack
);

    localparam int unsigned OFFSET_W = offsetWidth(LINE_WORDS);
    localparam int unsigned INDEX_W  = indexWidth(SETS);
    localparam int unsigned TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int unsigned WSEL_W   = OFFSET_W - 2;

    dcacheState_t state, stateNext;

    logic [LINE_WORDS-1:0][31:0] dataArr [SETS];
    logic [TAG_W-1:0]            tagArr  [SETS];
    logic [SETS-1:0]             validBits, dirtyBits;

    logic [INDEX_W-1:0] xferIndex, xferIndexNext;
    logic [TAG_W-1:0]   fillTag, fillTagNext;
    logic               rdNext, wrNext;
    logic [ADDR_W-1:0]  blkAddrNext;
    logic               storeHit, wbDone, fillDone, missStall;

    logic [INDEX_W-1:0] reqIndex;
    logic [TAG_W-1:0]   reqTag;
    logic [WSEL_W-1:0]  wordSel;
    logic               req, hit, victimDirty;
    logic [31:0]        mergedWord;

    assign reqIndex    = data_address_2DM[OFFSET_W +: INDEX_W];
    assign reqTag      = data_address_2DM[ADDR_W-1 -: TAG_W];
    assign wordSel     = data_address_2DM[2 +: WSEL_W];
    assign req         = MemRead | MemWrite;
    assign hit         = validBits[reqIndex] && (tagArr[reqIndex] == reqTag);
    assign victimDirty = validBits[reqIndex] & dirtyBits[reqIndex];

    assign data_read_fDC   = dataArr[reqIndex][wordSel];
    assign block_write_2DM = dataArr[xferIndex];
    assign DMISS           = RESET ? 1'b0 : missStall;

    dcache_store_merge uMerge (
        .oldWord    (dataArr[reqIndex][wordSel]),
        .storeData  (data_write_2DM),
        .mode       (DataWriteMode),
        .byteSel    (data_address_2DM[1:0]),
        .mergedWord (mergedWord)
    );

`ifdef DCACHE_FLUSH_EN
    logic [INDEX_W-1:0] flushCnt, flushCntNext;
    logic               sysArmed, sysArmedNext;
`else
    logic unusedSys;
    assign unusedSys = SYS;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        rdNext        = dBlkRead;
        wrNext        = dBlkWrite;
        blkAddrNext   = blk_addr;
        xferIndexNext = xferIndex;
        fillTagNext   = fillTag;
        storeHit      = 1'b0;
        wbDone        = 1'b0;
        fillDone      = 1'b0;
        missStall     = 1'b0;
`ifdef DCACHE_FLUSH_EN
        flushCntNext  = flushCnt;
        sysArmedNext  = sysArmed | ~SYS;
`endif
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    missStall     = 1'b1;
                    xferIndexNext = reqIndex;
                    fillTagNext   = reqTag;
                    if (victimDirty) begin
                        stateNext   = WB;
                        wrNext      = 1'b1;
                        blkAddrNext = {tagArr[reqIndex], reqIndex, OFFSET_W'(0)};
                    end else begin
                        stateNext   = FILL;
                        rdNext      = 1'b1;
                        blkAddrNext = {reqTag, reqIndex, OFFSET_W'(0)};
                    end
                end else begin
                    storeHit = MemWrite & hit;
`ifdef DCACHE_FLUSH_EN
                    if (SYS && sysArmed) begin
                        stateNext    = FLUSH;
                        flushCntNext = '0;
                        sysArmedNext = 1'b0;
                    end
`endif
                end
            end
            WB: begin
                missStall = 1'b1;
                if (blk_ack) begin
                    wbDone      = 1'b1;
                    wrNext      = 1'b0;
                    rdNext      = 1'b1;
                    blkAddrNext = {fillTag, xferIndex, OFFSET_W'(0)};
                    stateNext   = FILL;
                end
            end
            FILL: begin
                missStall = 1'b1;
                if (blk_ack) begin
                    fillDone  = 1'b1;
                    rdNext    = 1'b0;
                    stateNext = IDLE;
                end
            end
`ifdef DCACHE_FLUSH_EN
            // Written-back sets are rechecked clean on the following cycle.
            FLUSH: begin
                missStall = 1'b1;
                if (dBlkWrite) begin
                    if (blk_ack) begin
                        wbDone = 1'b1;
                        wrNext = 1'b0;
                    end
                end else if (validBits[flushCnt] && dirtyBits[flushCnt]) begin
                    wrNext        = 1'b1;
                    xferIndexNext = flushCnt;
                    blkAddrNext   = {tagArr[flushCnt], flushCnt, OFFSET_W'(0)};
                end else if (flushCnt == INDEX_W'(SETS - 1)) begin
                    stateNext = IDLE;
                end else begin
                    flushCntNext = flushCnt + INDEX_W'(1);
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            validBits <= '0;
            dirtyBits <= '0;
            dBlkRead  <= 1'b0;
            dBlkWrite <= 1'b0;
            blk_addr  <= '0;
            xferIndex <= '0;
            fillTag   <= '0;
`ifdef DCACHE_FLUSH_EN
            flushCnt  <= '0;
            sysArmed  <= 1'b1;
`endif
        end else begin
            dBlkRead  <= rdNext;
            dBlkWrite <= wrNext;
            blk_addr  <= blkAddrNext;
            xferIndex <= xferIndexNext;
            fillTag   <= fillTagNext;
`ifdef DCACHE_FLUSH_EN
            flushCnt  <= flushCntNext;
            sysArmed  <= sysArmedNext;
`endif
            if (storeHit) dirtyBits[reqIndex] <= 1'b1;
            if (wbDone)   dirtyBits[xferIndex] <= 1'b0;
            if (fillDone) begin
                validBits[xferIndex] <= 1'b1;
                dirtyBits[xferIndex] <= 1'b0;
            end
        end
    end

    // Data and tag storage carry no reset; validity is tracked separately.
    always_ff @(posedge CLK) begin
        if (storeHit) dataArr[reqIndex][wordSel] <= mergedWord;
        if (fillDone) begin
            dataArr[xferIndex] <= block_read_fDM;
            tagArr[xferIndex]  <= fillTag;
        end
    end

endmodule
